i2c_target_regbank: RTL
=======================

// Module: i2c_target_regbank
// PURPOSE
//   I2C target (responder) for the I2C host controllers in ibex_demo_system.
//   Presents a small byte-wide register bank at a fixed 7-bit address over an open-drain SCL/SDA pair.
//   Used as an on-FPGA loopback target for host bring-up, and to emulate simple ID devices on the HAT, QWIIC or mikroBUS pins.
//   The local side reads the bank directly and can also write it.
// PARAMETERS
//   TargetAddr    7'h50  7-bit I2C address this target responds to
//   NumRegs       16     number of 8-bit registers; power of 2, >=2; AW = $clog2(NumRegs)
//   FilterCycles  4      consecutive equal samples required before a filtered SCL/SDA level changes
// PORTS
//   clk_sys_i    in   1           system clock
//   rst_sys_ni   in   1           async active-low reset
//   scl_i        in   1           SCL pad input (async)
//   sda_i        in   1           SDA pad input (async)
//   scl_o        out  1           constant 0
//   scl_en_o     out  1           constant 0; no clock stretching
//   sda_o        out  1           constant 0
//   sda_en_o     out  1           1 = pull SDA low
//   regs_o       out  NumRegs*8   register bank; reg n at [8n+7:8n]
//   loc_we_i     in   1           local write strobe
//   loc_addr_i   in   AW          local write index
//   loc_wdata_i  in   8           local write data
//   wr_pulse_o   out  1           1-cycle pulse when an I2C write updates a register
//   wr_addr_o    out  AW          index of the register written by I2C (valid with wr_pulse_o)
//   busy_o       out  1           1 from address-match ACK until STOP/START/NACK-end
// BEHAVIOUR
// - Reset, asynchronous: sda_en_o=0, wr_pulse_o=0, wr_addr_o=0, busy_o=0, regs_o=0, pointer=0, FSM=IDLE.
// - Input conditioning: scl_i and sda_i each pass a 2-flop synchroniser, then a counter filter. The filtered level changes only after FilterCycles equal samples. Both lines have identical latency.
// - Edge detection, all on filtered levels:
//   - SCL rise = sample point.
//   - SCL fall = drive point.
//   - START/Sr = SDA falls while SCL is high.
//   - STOP = SDA rises while SCL is high.
// - START or Sr from any state: go to ADDR, clear the bit counter, release sda_en_o on the next cycle.
// - STOP from any state: go to IDLE, release sda_en_o on the next cycle.
// - Bits are shifted MSB first.
// - sda_en_o changes only on the cycle after a filtered SCL fall, never while SCL is high.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//   - ADDR: collect 8 bits. If [7:1]==TargetAddr, go to ADDR_ACK and latch R/W=bit0. Otherwise go to IGNORE (sda_en_o stays 0 until START/STOP).
//   - ADDR_ACK: drive the ACK bit low for 9th clock, then release on the following SCL fall. Write goes to PTR; read goes to RDATA and drives the MSB of reg[ptr] on that same fall.
//   - PTR: first written byte; pointer <= byte[AW-1:0] (upper bits ignored), then ACK.
//   - WDATA: at the 8th rise, reg[ptr] <= byte; wr_pulse_o=1 for 1 cycle; wr_addr_o=ptr; ptr<=ptr+1 mod NumRegs; then ACK.
//   - RDATA: sda_en_o = ~bit, so a 1 releases SDA. After the 8th bit, release SDA and ptr<=ptr+1 mod NumRegs. Sample the host ACK at the 9th rise. ACK (0) goes to RDATA with the next byte; NACK (1) goes to IGNORE.
// - busy_o = 1 in all states between ADDR_ACK and IGNORE/IDLE.
// - The pointer persists across transactions, so a read after a write-pointer-then-Sr returns reg[ptr].
// - Read data is the register snapshot loaded into the shift register at byte start; later local writes do not corrupt a byte in flight.
// - Local write: reg[loc_addr_i] <= loc_wdata_i when loc_we_i=1. If an I2C write lands in the same cycle, the I2C write wins for that register; a local write to a different index also completes.
// - Reset mid-transfer: SDA is released immediately (async), and the FSM ignores the bus until the next START.
// TESTING
// - Multi-byte write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> 4 ACKs, regs[3]=0x5A, regs[4]=0xC3, two wr_pulse_o with wr_addr_o=3 then 4, busy_o=0 after STOP.
// - Read with wrap: regs[15]=0x81, regs[0]=0x7E; write ptr 0x0F, Sr, 0xA1, read with ACK then NACK -> bytes 0x81, 0x7E; SDA released after NACK; ptr=1.
// - Address mismatch: START, 0xA2, 0x00, STOP -> sda_en_o never 1, regs unchanged, busy_o stays 0.
// - Glitch rejection: SCL low pulse of FilterCycles-1 cycles mid-byte -> no extra bit; the subsequent write stores the correct byte.
// - Collision: loc_we_i to reg 4 in the same cycle as an I2C write to reg 4 -> regs[4] = I2C data. Local write to reg 5 in that cycle -> also applied.
// - Reset during read while sda_en_o=1 -> sda_en_o=0 asynchronously, regs_o=0, bus ignored until the next START.

Source files
------------

// File: rtl/i2c_target_regbank.sv
// I2C target exposing a byte-wide register bank at a fixed 7-bit address.
// Filtered SCL/SDA drive a single bit-level FSM; the local side can also write the bank.
module i2c_target_regbank #(
    parameter logic [6:0] TargetAddr   = 7'h50,
    parameter int         NumRegs      = 16,
    parameter int         FilterCycles = 4,
    localparam int        AW           = $clog2(NumRegs)
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_ni,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 scl_o,
    output logic                 scl_en_o,
    output logic                 sda_o,
    output logic                 sda_en_o,
    output logic [NumRegs*8-1:0] regs_o,
    input  logic                 loc_we_i,
    input  logic [AW-1:0]        loc_addr_i,
    input  logic [7:0]           loc_wdata_i,
    output logic                 wr_pulse_o,
    output logic [AW-1:0]        wr_addr_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(FilterCycles + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_e;

    // Index 0 carries SCL, index 1 carries SDA so both share identical latency.
    logic [1:0]    sync_q1, sync_q2, filt_q, filt_prev_q;
    logic [CW-1:0] cnt_q [2];

    state_e        state_q;
    logic [2:0]    bit_cnt_q;
    logic          ack_phase_q;
    logic          rw_q;
    logic [7:0]    shift_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    regs_q [NumRegs];

    logic scl_f, scl_p, sda_f, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_o    = 1'b0;
    assign scl_en_o = 1'b0;
    assign sda_o    = 1'b0;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q1     <= 2'b11;
            sync_q2     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
        end else begin
            sync_q1     <= {sda_i, scl_i};
            sync_q2     <= sync_q1;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FilterCycles - 1)) begin
                    filt_q[i] <= sync_q2[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign scl_p     = filt_prev_q[0];
    assign sda_f     = filt_q[1];
    assign sda_p     = filt_prev_q[1];
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
    assign rx_byte   = {shift_q[6:0], sda_f};

    // ACK states use ack_phase_q: 0 = drive ACK on the next fall, 1 = ACK clock seen, leave on next fall.
    // Local writes come first so a same-cycle I2C write to the same register wins.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_en_o    <= 1'b0;
            wr_pulse_o  <= 1'b0;
            wr_addr_o   <= '0;
            busy_o      <= 1'b0;
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse_o <= 1'b0;
            if (loc_we_i) regs_q[loc_addr_i] <= loc_wdata_i;

            if (start_det) begin
                state_q     <= ADDR;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_en_o    <= 1'b0;
                busy_o      <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                sda_en_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shift_q   <= rx_byte;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == TargetAddr) begin
                                state_q     <= ADDR_ACK;
                                rw_q        <= rx_byte[0];
                                ack_phase_q <= 1'b0;
                                busy_o      <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    PTR, WDATA: if (scl_rise) begin
                        shift_q     <= rx_byte;
                        bit_cnt_q   <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_q <= 1'b0;
                            if (state_q == PTR) begin
                                state_q <= PTR_ACK;
                                ptr_q   <= rx_byte[AW-1:0];
                            end else begin
                                state_q       <= WDATA_ACK;
                                regs_q[ptr_q] <= rx_byte;
                                wr_pulse_o    <= 1'b1;
                                wr_addr_o     <= ptr_q;
                                ptr_q         <= ptr_q + 1'b1;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_rise) begin
                            ack_phase_q <= 1'b1;
                        end else if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_en_o <= 1'b1;
                            end else begin
                                bit_cnt_q <= '0;
                                if (state_q == ADDR_ACK && rw_q) begin
                                    state_q  <= RDATA;
                                    shift_q  <= regs_q[ptr_q];
                                    sda_en_o <= ~regs_q[ptr_q][7];
                                end else begin
                                    state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
                                    sda_en_o <= 1'b0;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q     <= RDATA_ACK;
                                ack_phase_q <= 1'b0;
                                ptr_q       <= ptr_q + 1'b1;
                            end
                        end else if (scl_fall) begin
                            sda_en_o <= ~shift_q[6];
                            shift_q  <= {shift_q[6:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= IGNORE;
                                busy_o  <= 1'b0;
                            end else begin
                                ack_phase_q <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_en_o <= 1'b0;
                            end else begin
                                state_q   <= RDATA;
                                bit_cnt_q <= '0;
                                shift_q   <= regs_q[ptr_q];
                                sda_en_o  <= ~regs_q[ptr_q][7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : g_regs
        assign regs_o[8*g +: 8] = regs_q[g];
    end

endmodule
